serial_addsub: RTL and testbench

Bit-serial WIDTH-bit adder/subtractor built around the one-bit add/sub cell function (a, b, cin, sub -> s, cout), applied one bit per clock, LSB first.
- Carry is held in a flip-flop between bits.
- Operands are accepted through a start/busy/done handshake.
- Sits in the ALU as the area-cheap, multi-cycle alternative to a parallel ripple adder.

---
 rtl/serial_addsub_if.sv | 26 ++
 rtl/serial_addsub.sv | 110 +++++++++++
 tb/tb_serial_addsub.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// master: requester (drives start and operands); slave: the serial_addsub core.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Subtraction is a + ~b + (1 - cin): b is inverted and the carry seeded with
// cin ^ sub when the operation is accepted.
// Optional: define SERIAL_ADDSUB_SAT_EN to saturate s on signed overflow.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_addsub_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;      // operand A, shifted right one bit per cycle
  logic [WIDTH-1:0] b_q;      // b ^ {WIDTH{sub}}, shifted likewise
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             sum_bit;
  logic             carry_d;
  logic             ovf_d;
  logic [WIDTH-1:0] s_d;
  logic             accept;

  assign accept = bus.start && (state_q != StRun);

  // One-bit full-add cell on the current LSBs plus the held carry.
  always_comb begin
    sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    // On the last bit carry_q is the carry into the MSB.
    ovf_d   = carry_q ^ carry_d;
    s_d     = {sum_bit, s_q[WIDTH-1:1]};
`ifdef SERIAL_ADDSUB_SAT_EN
    // a_q[0] holds the original A sign bit on the last bit.
    if ((cnt_q == CntLast) && ovf_d) begin
      s_d = a_q[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.cin ^ bus.sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          s_q     <= s_d;
          carry_q <= carry_d;
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          if (cnt_q == CntLast) begin
            cout_q  <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: WIDTH=8 vectors, handshake corner cases,
// asynchronous reset mid-operation, and an exhaustive WIDTH=2 sweep.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(2)) bus2 ();

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_addsub #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive operands and start, return #1 after the accepting edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  // Bounded wait for done; returns cycles after the start edge and busy count.
  task automatic wait8(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = bus8.busy ? 1 : 0;
    while (!bus8.done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (bus8.busy) busy_cnt++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic sub, input logic [7:0] es,
                     input logic ec, input logic eo);
    int cyc, bc;
    start8(a, b, cin, sub);
    wait8(cyc, bc);
    chk({tag, "_lat"}, cyc, 8);
    chk({tag, "_s"}, bus8.s, es);
    chk({tag, "_cout"}, bus8.cout, ec);
    chk({tag, "_ovf"}, bus8.ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, bc;
    logic [7:0] sat_pos, sat_neg;
    bus8.start = 0; bus8.a = 0; bus8.b = 0; bus8.cin = 0; bus8.sub = 0;
    bus2.start = 0; bus2.a = 0; bus2.b = 0; bus2.cin = 0; bus2.sub = 0;
`ifdef SERIAL_ADDSUB_SAT_EN
    sat_pos = 8'h7F; sat_neg = 8'h80;
`else
    sat_pos = 8'h80; sat_neg = 8'h7F;
`endif

    #3;
    chk("rst_busy", bus8.busy, 0);
    chk("rst_done", bus8.done, 0);
    chk("rst_s", bus8.s, 0);
    chk("rst_cout", bus8.cout, 0);
    chk("rst_ovf", bus8.ovf, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // First op with full timing checks.
    start8(8'h05, 8'h03, 1'b0, 1'b0);
    chk("t1_busy_after_start", bus8.busy, 1);
    wait8(cyc, bc);
    chk("t1_latency", cyc, 8);
    chk("t1_busy_cycles", bc, 8);
    chk("t1_busy_in_done", bus8.busy, 0);
    chk("t1_s", bus8.s, 8'h08);
    chk("t1_cout", bus8.cout, 0);
    chk("t1_ovf", bus8.ovf, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", bus8.done, 0);
    chk("t1_s_hold", bus8.s, 8'h08);

    op8("add_ff_01_c1", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, sat_pos, 1'b0, 1'b1);
    op8("sub_05_03", 8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    op8("sub_03_05", 8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_05_03_b1", 8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, sat_neg, 1'b1, 1'b1);

    // start during RUN is ignored.
    start8(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.sub = 1'b1; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    cyc = 4;
    while (!bus8.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ign_latency", cyc, 8);
    chk("ign_s", bus8.s, 8'h30);
    chk("ign_cout", bus8.cout, 0);

    // Back-to-back: start during the DONE cycle.
    chk("b2b_in_done", bus8.done, 1);
    start8(8'h40, 8'h02, 1'b1, 1'b0);
    chk("b2b_busy", bus8.busy, 1);
    chk("b2b_done_low", bus8.done, 0);
    wait8(cyc, bc);
    chk("b2b_latency", cyc, 8);
    chk("b2b_s", bus8.s, 8'h43);
    @(posedge clk); #1;

    // Async reset while bit 4 is being processed.
    start8(8'hF0, 8'h0F, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus8.busy, 0);
    chk("mid_rst_done", bus8.done, 0);
    chk("mid_rst_s", bus8.s, 0);
    chk("mid_rst_cout", bus8.cout, 0);
    chk("mid_rst_ovf", bus8.ovf, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_idle", bus8.busy, 0);
    op8("post_rst", 8'h23, 8'h45, 1'b0, 1'b0, 8'h68, 1'b0, 1'b0);

    // Exhaustive WIDTH=2 sweep against a signed/unsigned reference.
    for (int i = 0; i < 64; i++) begin
      logic [1:0] a, b, es;
      logic       ci, sb, ec, eo;
      int         ua, sa, sbv, v, r;
      a = 2'(i[1:0]); b = 2'(i[3:2]); ci = i[4]; sb = i[5];
      ua  = int'(a);
      sa  = a[1] ? ua - 4 : ua;
      sbv = b[1] ? int'(b) - 4 : int'(b);
      if (!sb) begin
        r = ua + int'(b) + int'(ci);
        v = sa + sbv + int'(ci);
      end else begin
        r = ua + (3 - int'(b)) + (1 - int'(ci));
        v = sa - sbv - int'(ci);
      end
      es = 2'(r % 4);
      ec = (r >= 4);
      eo = (v > 1) || (v < -2);
`ifdef SERIAL_ADDSUB_SAT_EN
      if (eo) es = a[1] ? 2'b10 : 2'b01;
`endif
      bus2.a = a; bus2.b = b; bus2.cin = ci; bus2.sub = sb; bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      cyc = 0;
      while (!bus2.done && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk($sformatf("w2_lat_%0d", i), cyc, 2);
      chk($sformatf("w2_s_%0d", i), bus2.s, es);
      chk($sformatf("w2_cout_%0d", i), bus2.cout, ec);
      chk($sformatf("w2_ovf_%0d", i), bus2.ovf, eo);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
